// File: rtl/logic_burst_ctrl.sv
// logic_burst_ctrl
// Sequences a burst of operand beats into an external combinational 8-bit
// AND/OR unit. It rebuilds the selected logic function from the unit's AND and
// OR outputs and chains each result into an accumulator. After the last beat it
// presents one result with flags.
//
// Handshakes: a transfer happens on any rising clk edge where valid and ready
// are both 1. The producer holds its payload until that edge. Here cmd_ready
// and rsp_valid are registered and depend only on state. They never depend
// combinationally on the partner's valid/ready.
module logic_burst_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_last,
    output logic [7:0]       lu_x,
    output logic [7:0]       lu_y,
    input  logic [7:0]       lu_zand,
    input  logic [7:0]       lu_zor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_zero,
    output logic             rsp_parity,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rsp_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // state_q is left as a typed, named register so checkers can bind to it
    state_t            state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic [7:0]        f;
    logic              beat_acc;
    logic              rsp_fire;
    logic              is_ill;

    // Operand routing: the first beat takes cmd_a, later beats chain the accumulator
    always_comb begin
        lu_y = cmd_b;
        lu_x = (state_q == ST_IDLE) ? cmd_a : acc_q;
    end

    // Rebuild the selected function from the unit's AND/OR outputs only
    always_comb begin
        f = lu_zand;
        unique case (cmd_op)
            OP_AND:  f = lu_zand;
            OP_OR:   f = lu_zor;
            OP_XOR:  f = lu_zor & ~lu_zand;
            OP_NAND: f = ~lu_zand;
            OP_NOR:  f = ~lu_zor;
            OP_XNOR: f = ~(lu_zor & ~lu_zand);
            OP_ANDN: f = lu_zor & ~lu_y;
            OP_ILL:  f = lu_x;
            default: f = lu_x;
        endcase
    end

    // Next-state, accumulator, counter and flag computation
    always_comb begin
        beat_acc    = cmd_valid & cmd_ready_q;
        rsp_fire    = rsp_valid_q & rsp_ready;
        is_ill      = (cmd_op == OP_ILL);
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        err_d       = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (beat_acc) begin
                    acc_d   = f;
                    count_d = CNT_ONE;
                    err_d   = is_ill;
                    state_d = cmd_last ? ST_RESP : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat_acc) begin
                    acc_d   = f;
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
                    err_d   = err_q | is_ill;
                    state_d = cmd_last ? ST_RESP : ST_ACCUM;
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d != ST_RESP);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // Single state register; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= 8'h00;
            count_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Response fields come straight from registers, so they hold while stalled
    always_comb begin
        cmd_ready  = cmd_ready_q;
        rsp_valid  = rsp_valid_q;
        rsp_data   = acc_q;
        rsp_zero   = (acc_q == 8'h00);
        rsp_parity = ^acc_q;
        rsp_err    = err_q;
        rsp_count  = count_q;
    end

endmodule

// File: tb/tb_logic_burst_ctrl.sv
// tb_logic_burst_ctrl
// Directed bench for logic_burst_ctrl. A combinational model of the AND/OR unit
// sits on the lu_* ports.
module tb_logic_burst_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic             cmd_last;
    logic [7:0]       lu_x;
    logic [7:0]       lu_y;
    logic [7:0]       lu_zand;
    logic [7:0]       lu_zor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             rsp_zero;
    logic             rsp_parity;
    logic             rsp_err;
    logic [CNT_W-1:0] rsp_count;

    int checks;
    int failures;

    logic [7:0] beat_lu_x;
    logic       beat_ready;

    assign lu_zand = lu_x & lu_y;
    assign lu_zor  = lu_x | lu_y;

    logic_burst_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_last   (cmd_last),
        .lu_x       (lu_x),
        .lu_y       (lu_y),
        .lu_zand    (lu_zand),
        .lu_zor     (lu_zor),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_parity (rsp_parity),
        .rsp_err    (rsp_err),
        .rsp_count  (rsp_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: present one beat at the falling edge and let the next rising edge
    // take it. The lu_x and cmd_ready seen during the beat are recorded.
    task automatic beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic last);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_last  = last;
        #1;
        beat_lu_x  = lu_x;
        beat_ready = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    // Driver: complete the response handshake with one cycle of rsp_ready
    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_a = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        checks++;
        if (rsp_zero !== 1'b1) begin failures++; $display("FAIL reset_rsp_zero got=%b exp=1", rsp_zero); end
        checks++;
        if (rsp_parity !== 1'b0 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL reset_parity_err got=%b%b exp=00", rsp_parity, rsp_err);
        end
        checks++;
        if (rsp_count !== 4'd0) begin failures++; $display("FAIL reset_rsp_count got=%0d exp=0", rsp_count); end
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++;
        if (lu_x !== 8'hA5) begin failures++; $display("FAIL reset_lu_x got=%h exp=a5", lu_x); end
    endtask

    task automatic test_single_and();
        beat(3'd0, 8'hF0, 8'h3C, 1'b1);
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL and_rsp_valid got=%b exp=1", rsp_valid); end
        checks++;
        if (rsp_data !== 8'h30) begin failures++; $display("FAIL and_rsp_data got=%h exp=30", rsp_data); end
        checks++;
        if ({rsp_zero, rsp_parity, rsp_err} !== 3'b000) begin
            failures++; $display("FAIL and_flags got=%b exp=000", {rsp_zero, rsp_parity, rsp_err});
        end
        checks++;
        if (rsp_count !== 4'd1) begin failures++; $display("FAIL and_count got=%0d exp=1", rsp_count); end
        take_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL and_after_hs got=%b%b exp=01", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_chained();
        beat(3'd1, 8'h01, 8'h02, 1'b0);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL chain_mid_valid got=%b exp=0", rsp_valid); end
        beat(3'd2, 8'hEE, 8'h03, 1'b1);
        checks++;
        if (beat_lu_x !== 8'h03) begin failures++; $display("FAIL chain_lu_x got=%h exp=03", beat_lu_x); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin
            failures++; $display("FAIL chain_data got=%b/%h exp=1/00", rsp_valid, rsp_data);
        end
        checks++;
        if (rsp_zero !== 1'b1 || rsp_parity !== 1'b0) begin
            failures++; $display("FAIL chain_flags got=%b%b exp=10", rsp_zero, rsp_parity);
        end
        checks++;
        if (rsp_count !== 4'd2) begin failures++; $display("FAIL chain_count got=%0d exp=2", rsp_count); end
        take_rsp();
    endtask

    task automatic test_backpressure();
        // XOR 0x01 ^ 0x00 = 0x01: odd parity
        beat(3'd2, 8'h01, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            // cmd beats offered while stalled must be ignored
            cmd_valid = 1'b1;
            cmd_op    = 3'd1;
            cmd_a     = 8'hFF;
            cmd_b     = 8'hFF;
            cmd_last  = 1'b1;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold_hs cyc=%0d got=%b%b exp=10", i, rsp_valid, cmd_ready);
            end
            checks++;
            if ({rsp_data, rsp_zero, rsp_parity, rsp_err, rsp_count} !== {8'h01, 1'b0, 1'b1, 1'b0, 4'd1}) begin
                failures++; $display("FAIL bp_hold_data cyc=%0d got=%h/%b%b%b/%0d exp=01/010/1", i,
                                     rsp_data, rsp_zero, rsp_parity, rsp_err, rsp_count);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        take_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got=%b%b exp=01", rsp_valid, cmd_ready);
        end
        checks++;
        if (rsp_data !== 8'h01) begin failures++; $display("FAIL bp_ignored_cmd got=%h exp=01", rsp_data); end
    endtask

    task automatic test_illegal();
        beat(3'd7, 8'h5A, 8'h33, 1'b0);
        beat(3'd4, 8'h00, 8'h0F, 1'b1);
        checks++;
        if (rsp_data !== 8'hA0) begin failures++; $display("FAIL ill_data got=%h exp=a0", rsp_data); end
        checks++;
        if ({rsp_err, rsp_parity, rsp_zero} !== 3'b100) begin
            failures++; $display("FAIL ill_flags got=%b exp=100", {rsp_err, rsp_parity, rsp_zero});
        end
        checks++;
        if (rsp_count !== 4'd2) begin failures++; $display("FAIL ill_count got=%0d exp=2", rsp_count); end
        take_rsp();
        // err must not leak into the next burst: XNOR 0x0F,0x00 -> 0xF0
        beat(3'd5, 8'h0F, 8'h00, 1'b1);
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== 8'hF0) begin
            failures++; $display("FAIL ill_clear got=%b/%h exp=0/f0", rsp_err, rsp_data);
        end
        take_rsp();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            beat(3'd6, 8'hFF, 8'h01, (i == 19));
            checks++;
            if (beat_ready !== 1'b1) begin failures++; $display("FAIL sat_ready beat=%0d got=%b exp=1", i, beat_ready); end
        end
        checks++;
        if (rsp_data !== 8'hFE) begin failures++; $display("FAIL sat_data got=%h exp=fe", rsp_data); end
        checks++;
        if (rsp_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", rsp_count); end
        take_rsp();
    endtask

    task automatic test_reset_mid_burst();
        beat(3'd1, 8'h11, 8'h22, 1'b0);
        beat(3'd1, 8'h00, 8'h44, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_hs got=%b%b exp=01", rsp_valid, cmd_ready);
        end
        checks++;
        if (rsp_count !== 4'd0 || rsp_data !== 8'h00) begin
            failures++; $display("FAIL rstmid_clear got=%0d/%h exp=0/00", rsp_count, rsp_data);
        end
        beat(3'd3, 8'hFF, 8'hFF, 1'b1);
        checks++;
        if (beat_lu_x !== 8'hFF) begin failures++; $display("FAIL rstmid_lu_x got=%h exp=ff", beat_lu_x); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_count !== 4'd1) begin
            failures++; $display("FAIL rstmid_nand got=%b/%h/%0d exp=1/00/1", rsp_valid, rsp_data, rsp_count);
        end
        take_rsp();
    endtask

    task automatic test_back_to_back();
        // first beat of the next burst offered on the cycle right after the handshake
        beat(3'd0, 8'hFF, 8'h0C, 1'b1);
        take_rsp();
        beat(3'd1, 8'h80, 8'h01, 1'b1);
        checks++;
        if (beat_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", beat_ready); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h81 || rsp_parity !== 1'b0) begin
            failures++; $display("FAIL b2b_data got=%b/%h/%b exp=1/81/0", rsp_valid, rsp_data, rsp_parity);
        end
        take_rsp();
    endtask

    // Sequence of scenarios and the final report
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_last  = 1'b0;
        rsp_ready = 1'b0;
        beat_lu_x  = 8'h00;
        beat_ready = 1'b0;
        test_reset();
        test_single_and();
        test_chained();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_reset_mid_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_burst_ctrl.md
# logic_burst_ctrl

Sequencing controller that sits in front of the 8-bit bitwise AND/OR unit. It accepts a burst of operand beats over a valid/ready command port and drives each beat's operands into the unit. It derives the selected logic function from the unit's AND and OR outputs and folds the results into an accumulator. When the burst ends, it returns one result with flags over a valid/ready response port.

## Interface
Parameters:
- CNT_W, 4: width of the beat counter reported in the response.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command beat present.
- cmd_ready  out  1  controller accepts a beat this cycle.
- cmd_op  in  3  logic function for this beat.
- cmd_a  in  8  first operand; used only on the first beat of a burst.
- cmd_b  in  8  second operand; used on every beat.
- cmd_last  in  1  this beat ends the burst.
- lu_x  out  8  X operand to the AND/OR unit.
- lu_y  out  8  Y operand to the AND/OR unit.
- lu_zand  in  8  X&Y from the unit.
- lu_zor  in  8  X|Y from the unit.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  8  burst result.
- rsp_zero  out  1  rsp_data == 0.
- rsp_parity  out  1  XOR of all rsp_data bits.
- rsp_err  out  1  at least one beat in the burst carried an illegal op.
- rsp_count  out  CNT_W  beats in the burst, saturating at 2^CNT_W-1.

## Operation
- States:
  - IDLE: waiting for the first beat.
  - ACCUM: a burst is in progress.
  - RESP: a result is pending.
- Beat accepted when cmd_valid & cmd_ready.
- cmd_ready = 1 in IDLE and ACCUM, 0 in RESP.
- Operand routing is combinational:
  - lu_y = cmd_b.
  - lu_x = cmd_a in IDLE, acc in ACCUM.
  - In RESP, lu_x = acc.
- Result f is computed from Z&=lu_zand and Z|=lu_zor only:
  - 0 AND = Z&
  - 1 OR = Z|
  - 2 XOR = Z| & ~Z&
  - 3 NAND = ~Z&
  - 4 NOR = ~Z|
  - 5 XNOR = ~(Z| & ~Z&)
  - 6 ANDN = Z| & ~lu_y (X & ~Y)
  - 7 illegal: f = lu_x, and the sticky err bit is set.
- On an accepted beat, acc <= f.
- On a first beat: count <= 1 and err <= (op==7). On later beats: count increments, saturating, and err ORs in (op==7).
- Transitions:
  - IDLE -> ACCUM on an accepted beat with cmd_last=0.
  - IDLE -> RESP on an accepted beat with cmd_last=1 (single-beat burst).
  - ACCUM -> ACCUM on an accepted beat with cmd_last=0.
  - ACCUM -> RESP on an accepted beat with cmd_last=1.
  - RESP -> IDLE when rsp_valid & rsp_ready.
- Response values:
  - rsp_data = acc.
  - rsp_zero and rsp_parity are derived from acc.
  - rsp_err and rsp_count are the registered values.
- All response outputs are held stable while rsp_valid=1 and rsp_ready=0.
- Reset: state IDLE, acc=0, count=0, err=0. Consequently, out of reset: rsp_valid=0, rsp_data=0, rsp_zero=1, rsp_parity=0, rsp_err=0, rsp_count=0, cmd_ready=1, lu_x=cmd_a.
- Reset asserted mid-burst or with a response pending discards the burst and the response. There is no partial response.

## Timing
- The unit is combinational. f is valid in the same cycle lu_x/lu_y are driven.
- Throughput: one beat per cycle while in IDLE/ACCUM.
- Latency: rsp_valid rises the cycle after the last beat is accepted.
- Response handshake completes on the cycle rsp_valid & rsp_ready. rsp_valid drops and cmd_ready rises the next cycle. There is no same-cycle bypass, so a new burst's first beat can be accepted at the earliest 1 cycle after the handshake.
- cmd_* inputs are ignored while cmd_ready=0.
- rst has priority over every handshake in the same cycle.

## Test plan
- Single-beat AND: op=0, a=0xF0, b=0x3C, last=1 -> next cycle rsp_valid=1, data=0x30, zero=0, parity=0, count=1, err=0.
- Chained burst: beat1 OR a=0x01 b=0x02; beat2 XOR b=0x03 last=1 -> data=0x00, zero=1, parity=0, count=2; lu_x=0x03 on beat2.
- Backpressure: complete the burst, hold rsp_ready=0 for 3 cycles -> rsp_* stable and cmd_ready=0 throughout; rsp_ready=1 -> handshake, cmd_ready=1 the following cycle.
- Illegal op: beat1 op=7 a=0x5A; beat2 NOR b=0x0F last=1 -> data=0xA0, err=1, parity=0, count=2.
- Saturation: with CNT_W=4, a 20-beat ANDN burst, a=0xFF, b=0x01 every beat -> data=0xFE, count=15.
- Reset mid-burst: after 2 of 4 beats, pulse rst -> no response, rsp_valid=0, cmd_ready=1. A following single-beat burst, NAND a=0xFF b=0xFF -> data=0x00, count=1.
